vshift_seq: RTL and testbench

Sequencer for the lane's SIMD shifter datapath. Accepts one vector shift instruction (direction, signedness, one-hot SEW, VL) and streams the packed operand words through the shifter. Registers the shifter's operands and result, and emits result words with per-byte tail enables. Sits between the lane issue/operand-read logic and the lane writeback port; the shifter itself stays combinational and external.

---
 rtl/vshift_seq.sv | 148 ++++++++++++++
 tb/tb_vshift_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vshift_seq.sv
// Sequencer for the lane SIMD shifter: latches one vector shift instruction,
// streams operand words through a registered S1/S2 pipeline around the external shifter.
module vshift_seq #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
  parameter int VL_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic                          issue_right,
  input  logic                          issue_sign,
  input  logic [SEW_WIDTH-1:0]          issue_sew,
  input  logic [VL_WIDTH-1:0]           issue_vl,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_WIDTH-1:0]          in_opa,
  input  logic [MAX_WIDTH-1:0]          in_opb,
  output logic                          sh_right,
  output logic                          sh_sign,
  output logic [SEW_WIDTH-1:0]          sh_sew,
  output logic [MAX_WIDTH-1:0]          sh_opa,
  output logic [MAX_WIDTH-1:0]          sh_opb,
  input  logic [MAX_WIDTH-1:0]          sh_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_WIDTH-1:0]          out_data,
  output logic [MAX_WIDTH/MIN_WIDTH-1:0] out_be,
  output logic [VL_WIDTH-1:0]           out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int RATIO = MAX_WIDTH / MIN_WIDTH;
  localparam int LOG_R = $clog2(RATIO);
  localparam int BW    = VL_WIDTH + SEW_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [VL_WIDTH-1:0] VL_ONE  = 1;
  localparam logic [RATIO-1:0]    BE_ONES = '1;

  logic [1:0]          state;
  logic [VL_WIDTH-1:0] r_vl;
  logic [VL_WIDTH-1:0] in_cnt;
  logic                s1_v;
  logic [VL_WIDTH-1:0] s1_idx;
  logic                s2_v;

  logic [BW-1:0]       bytes;
  logic [LOG_R-1:0]    rem;
  logic [VL_WIDTH-1:0] nwords;
  logic                s1_last;
  logic [RATIO-1:0]    s1_be;
  logic                advance;
  logic                in_fire;
  logic                out_fire;

  // bytes = vl * ebytes; ebytes is a power of two, so the product is a shift
  always_comb begin
    bytes = '0;
    for (int unsigned j = 0; j < SEW_WIDTH; j++) begin
      if (sh_sew[j]) bytes = BW'(r_vl) << (SEW_WIDTH - 1 - j);
    end
  end

  assign rem     = bytes[LOG_R-1:0];
  assign nwords  = VL_WIDTH'(bytes >> LOG_R) + VL_WIDTH'(rem != '0);
  assign s1_last = (s1_idx == nwords - VL_ONE);
  assign s1_be   = (s1_last && rem != '0) ? ~(BE_ONES << rem) : '1;

  assign advance     = s1_v && (!s2_v || out_ready);
  assign in_ready    = (state == S_RUN) && (in_cnt < nwords) && (!s1_v || advance);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = s2_v && out_ready;
  assign issue_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign out_valid   = s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      r_vl     <= '0;
      in_cnt   <= '0;
      sh_right <= 1'b0;
      sh_sign  <= 1'b0;
      sh_sew   <= '0;
      err      <= 1'b0;
      s1_v     <= 1'b0;
      s1_idx   <= '0;
      sh_opa   <= '0;
      sh_opb   <= '0;
      s2_v     <= 1'b0;
      out_data <= '0;
      out_be   <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            sh_right <= issue_right;
            sh_sign  <= issue_sign;
            sh_sew   <= issue_sew;
            r_vl     <= issue_vl;
            in_cnt   <= '0;
            if (!$onehot(issue_sew))  err   <= 1'b1;
            else if (issue_vl == '0)  state <= S_FIN;
            else                      state <= S_RUN;
          end
        end
        S_RUN:   if (out_fire && out_last) state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (in_fire) begin
        s1_v   <= 1'b1;
        sh_opa <= in_opa;
        sh_opb <= in_opb;
        s1_idx <= in_cnt;
        in_cnt <= in_cnt + VL_ONE;
      end else if (advance) begin
        s1_v <= 1'b0;
      end

      // advance takes priority so a draining S2 reloads in the same cycle
      if (advance) begin
        s2_v     <= 1'b1;
        out_data <= sh_result;
        out_be   <= s1_be;
        out_idx  <= s1_idx;
        out_last <= s1_last;
      end else if (out_fire) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vshift_seq.sv
// Scoreboard bench for vshift_seq: random instructions and operands, an element-wise
// shifter model on the sh_* port, and a queue of expected result words.
module tb_vshift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_right, issue_sign;
  logic [3:0]  issue_sew;
  logic [7:0]  issue_vl;
  logic        in_valid, in_ready;
  logic [63:0] in_opa, in_opb;
  logic        sh_right, sh_sign;
  logic [3:0]  sh_sew;
  logic [63:0] sh_opa, sh_opb, sh_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_be, out_idx;
  logic        out_last, busy, done, err;

  vshift_seq #(.MIN_WIDTH(8), .MAX_WIDTH(64), .VL_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_right(issue_right),
    .issue_sign(issue_sign), .issue_sew(issue_sew), .issue_vl(issue_vl),
    .in_valid(in_valid), .in_ready(in_ready), .in_opa(in_opa), .in_opb(in_opb),
    .sh_right(sh_right), .sh_sign(sh_sign), .sh_sew(sh_sew),
    .sh_opa(sh_opa), .sh_opb(sh_opb), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    int          idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, mode = 0, exp_done = 0, done_seen = 0;
  int   cur_ew, cur_nw, cur_vl;
  logic cur_right, cur_sign;

  function automatic int sew_to_ew(input logic [3:0] s);
    case (s)
      4'b0001: return 64;
      4'b0010: return 32;
      4'b0100: return 16;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  // element-wise shift; amount is the low log2(ew) bits of each opb element
  function automatic logic [63:0] shift_word(input logic [63:0] a, input logic [63:0] b,
                                             input int ew, input logic right, input logic sgn);
    logic [63:0] r, m, ea, v;
    int s;
    r = '0;
    if (ew == 0) return r;
    m = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    for (int e = 0; e < 64 / ew; e++) begin
      ea = (a >> (e * ew)) & m;
      s  = int'((b >> (e * ew)) & 64'(ew - 1));
      if (right) begin
        v = (sgn && ea[ew-1]) ? (ea | ~m) : ea;
        v = sgn ? 64'($signed(v) >>> s) : (v >> s);
      end else begin
        v = ea << s;
      end
      r = r | ((v & m) << (e * ew));
    end
    return r;
  endfunction

  always_comb sh_result = shift_word(sh_opa, sh_opb, sew_to_ew(sh_sew), sh_right, sh_sign);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // monitor: pops the scoreboard on every out handshake
  logic        hold_pend = 1'b0, done_pend = 1'b0, hold_last;
  logic [63:0] hold_data;
  logic [7:0]  hold_be, hold_idx;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      done_pend = 1'b0;
    end else begin
      if (done_pend) check("done_pulse", done, 1'b1);
      if (done) done_seen++;
      if (hold_pend)
        check("out_hold", {out_valid, out_last, out_be, out_idx, out_data},
              {1'b1, hold_last, hold_be, hold_idx, hold_data});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", out_idx, 8'hxx);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_be",   out_be,   e.be);
          check("out_idx",  out_idx,  e.idx[7:0]);
          check("out_last", out_last, e.last);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_be   = out_be;
      hold_idx  = out_idx;
      hold_last = out_last;
      done_pend = out_valid && out_ready && out_last;
    end
  end

  task automatic issue(input logic right, input logic sign, input logic [3:0] sew, input int vl);
    int t = 0;
    @(negedge clk);
    while (!issue_ready && t < 300) begin @(negedge clk); t++; end
    if (!issue_ready) timeout("issue_wait");
    issue_valid = 1'b1; issue_right = right; issue_sign = sign;
    issue_sew = sew; issue_vl = vl[7:0];
    cur_right = right; cur_sign = sign; cur_vl = vl;
    cur_ew = sew_to_ew(sew);
    cur_nw = (vl * (cur_ew / 8) + 7) / 8;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] a, input logic [63:0] b, input int idx,
                           output int acc_cyc);
    exp_t x;
    int bytes, rm, t;
    bytes  = cur_vl * (cur_ew / 8);
    rm     = bytes % 8;
    x.data = shift_word(a, b, cur_ew, cur_right, cur_sign);
    x.idx  = idx;
    x.last = (idx == cur_nw - 1);
    x.be   = (x.last && rm != 0) ? 8'((1 << rm) - 1) : 8'hFF;
    q.push_back(x);
    in_valid = 1'b1; in_opa = a; in_opb = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    acc_cyc = cyc;
    if (!in_ready) begin
      timeout("in_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_instr();
    int t = 0;
    in_valid = 1'b1;
    @(negedge clk);
    check("no_extra_word", in_ready, 1'b0);
    in_valid = 1'b0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    if (busy) timeout("idle_wait");
    exp_done++;
  endtask

  task automatic run_instr(input logic right, input logic sign, input logic [3:0] sew,
                           input int vl, input int gap_max);
    int ac;
    issue(right, sign, sew, vl);
    check("sh_sew", sh_sew, sew);
    check("sh_dir_sign", {sh_right, sh_sign}, {right, sign});
    for (int i = 0; i < cur_nw; i++) begin
      send_word({$urandom, $urandom}, {$urandom, $urandom}, i, ac);
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
    finish_instr();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {issue_ready, in_ready, out_valid, busy, done, err}, 6'b100000);
    check({tag, "_out"}, {out_data, out_be, out_idx, out_last}, '0);
    check({tag, "_sh"}, {sh_right, sh_sign, sh_sew, sh_opa, sh_opb}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int ac, t;
    logic [3:0] rsew;
    rst = 1'b1;
    issue_valid = 1'b0; issue_right = 1'b0; issue_sign = 1'b0;
    issue_sew = '0; issue_vl = '0;
    in_valid = 1'b0; in_opa = '0; in_opb = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 8b elements, vl=11: two words, be FF then 07
    mode = 0;
    run_instr(1'b1, 1'b0, 4'b1000, 11, 0);

    // 32b left shift with fixed operands; output two cycles after acceptance
    issue(1'b0, 1'b0, 4'b0010, 2);
    send_word(64'h00000001_80000000, 64'h00000001_00000001, 0, ac);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    if (!out_valid) timeout("latency_wait");
    check("latency", cyc - ac, 2);
    check("data32", out_data, 64'h00000002_00000000);
    finish_instr();

    // 64b, vl=3, continuous input with 3 stalled cycles on the output
    mode = 2;
    issue(1'b0, 1'b1, 4'b0001, 3);
    fork
      begin
        int a2;
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, {$urandom, $urandom}, i, a2);
      end
      begin
        int t2 = 0;
        @(negedge clk);
        while (!out_valid && t2 < 20) begin @(negedge clk); t2++; end
        check("stall_in_ready", in_ready, 1'b0);
        repeat (2) begin
          @(negedge clk);
          check("stall_hold", {out_valid, in_ready}, 2'b10);
        end
        mode = 0;
      end
    join
    finish_instr();

    // vl=0: straight to done, no data
    issue(1'b0, 1'b0, 4'b0100, 0);
    @(negedge clk);
    check("vl0_fin", {done, busy, issue_ready, in_ready, out_valid}, 5'b11000);
    @(negedge clk);
    check("vl0_idle", {done, busy, issue_ready}, 3'b001);
    exp_done++;

    // illegal SEW codes
    issue(1'b0, 1'b0, 4'b0000, 5);
    @(negedge clk);
    check("err_zero", {err, busy, issue_ready}, 3'b101);
    @(negedge clk);
    check("err_clear", err, 1'b0);
    issue(1'b1, 1'b1, 4'b0110, 5);
    @(negedge clk);
    check("err_multi", {err, busy, issue_ready}, 3'b101);
    @(negedge clk);
    check("err_clear2", err, 1'b0);

    // reset with S1 and S2 both occupied
    mode = 2;
    issue(1'b1, 1'b1, 4'b0001, 10);
    send_word({$urandom, $urandom}, {$urandom, $urandom}, 0, ac);
    send_word({$urandom, $urandom}, {$urandom, $urandom}, 1, ac);
    @(negedge clk);
    check("pre_reset_full", {out_valid, busy}, 2'b11);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    mode = 0;
    run_instr(1'b0, 1'b1, 4'b0100, 9, 0);

    // randomized instructions under random backpressure, plus the largest vl
    mode = 1;
    for (int n = 0; n < 14; n++) begin
      rsew = 4'b0001 << $urandom_range(0, 3);
      run_instr(1'($urandom), 1'($urandom), rsew, $urandom_range(1, 40), 2);
    end
    run_instr(1'b1, 1'b1, 4'b1000, 255, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    check("done_count", done_seen, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
